// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared types and elaboration helpers for the key conditioner.
//
// Contents:
//   kc_state_t   per-channel press state (RELEASED / HELD / REPEATING)
//   max_int      larger of two integers
//   timer_width  bit width of the auto-repeat down-counter
// ---------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        KC_RELEASED  = 2'd0,
        KC_HELD      = 2'd1,
        KC_REPEATING = 2'd2
    } kc_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The timer only ever holds values up to max(delay, period) - 1.
    // If both lengths are 1, that range needs no bits at all.
    // A one-bit floor keeps the vector legal in that degenerate case.
    function automatic int timer_width(input int delay_cyc, input int period_cyc);
        int m;
        m = max_int(delay_cyc, period_cyc);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_channel.sv
// ---------------------------------------------------------------------------
// key_channel
// One input channel of the key conditioner:
//   - 2-flop synchroniser on the polarity-normalised pin (1 = pressed)
//   - debounce counter: a level change is accepted after DEBOUNCE_CYC
//     consecutive cycles of disagreement
//   - press/release/repeat FSM with an auto-repeat down-counter
//
// Ports:
//   clk_sys        in   clock, rising edge
//   reset          in   synchronous, active-high
//   raw            in   asynchronous pin level
//   level          out  debounced pressed state (1 = pressed)
//   press          out  one-cycle pulse on accepted press
//   release_pulse  out  one-cycle pulse on accepted release
//   repeat_pulse   out  one-cycle auto-repeat pulse while held
//
// State table:
//   state         | meaning
//   KC_RELEASED   | level = 0, waiting for an accepted press
//   KC_HELD       | pressed, timer counting down to the first repeat
//   KC_REPEATING  | pressed, timer counting down between repeats
// ---------------------------------------------------------------------------
module key_channel
    import key_pkg::*;
#(
    parameter logic ACTIVE_LOW        = 1'b1,
    parameter logic REPEAT_EN         = 1'b1,
    parameter int   DEBOUNCE_CYC      = 1_000_000,
    parameter int   REPEAT_DELAY_CYC  = 25_000_000,
    parameter int   REPEAT_PERIOD_CYC = 5_000_000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int TW = timer_width(REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC);

    // The toggle happens on the edge where the counter would have reached
    // DEBOUNCE_CYC, so a clean edge shows up 2 + DEBOUNCE_CYC cycles later.
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY_CYC - 1);
    localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD_CYC - 1);

    logic [1:0]    sync;
    logic [DW-1:0] db_cnt;
    logic [TW-1:0] timer;
    kc_state_t     state;
    logic          accept;

    // The debounced level flips on this cycle.
    // The direction follows from the current value of level.
    assign accept = (sync[1] != level) && (db_cnt == DB_LAST);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync          <= 2'b00;
            db_cnt        <= '0;
            level         <= 1'b0;
            timer         <= '0;
            state         <= KC_RELEASED;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync          <= {sync[0], raw ^ ACTIVE_LOW};
            press         <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;

            if (sync[1] == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt <= '0;
                level  <= ~level;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            // The release check comes first in each pressed state.
            // A repeat due on the same cycle is therefore dropped.
            case (state)
                KC_RELEASED: begin
                    if (accept) begin
                        state <= KC_HELD;
                        press <= 1'b1;
                        timer <= DELAY_LOAD;
                    end
                end
                KC_HELD: begin
                    if (accept) begin
                        state         <= KC_RELEASED;
                        release_pulse <= 1'b1;
                    end else if (REPEAT_EN) begin
                        if (timer == '0) begin
                            state        <= KC_REPEATING;
                            repeat_pulse <= 1'b1;
                            timer        <= PERIOD_LOAD;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                end
                KC_REPEATING: begin
                    if (accept) begin
                        state         <= KC_RELEASED;
                        release_pulse <= 1'b1;
                    end else if (timer == '0) begin
                        repeat_pulse <= 1'b1;
                        timer        <= PERIOD_LOAD;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= KC_RELEASED;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
// Multi-channel conditioner for board pushbuttons and slide switches.
// Each channel is synchronised and debounced.
// Each channel produces a clean level plus one-cycle press, release and
// auto-repeat pulses.
//
// Ports:
//   CLOCK_50       in   sole clock, rising edge
//   RESET          in   synchronous, active-high reset
//   raw            in   [N_CH] asynchronous pin levels
//   level          out  [N_CH] debounced pressed state (1 = pressed)
//   press          out  [N_CH] one-cycle pulse when level rises
//   release_pulse  out  [N_CH] one-cycle pulse when level falls
//   repeat_pulse   out  [N_CH] one-cycle auto-repeat pulse while held
//   any_press      out  OR of press (combinational from registered press)
//
// The release and repeat outputs carry a _pulse suffix.
// This is because release and repeat are reserved words in SystemVerilog.
// ---------------------------------------------------------------------------
module key_conditioner
    import key_pkg::*;
#(
    parameter int              N_CH              = 4,
    parameter logic [N_CH-1:0] ACTIVE_LOW        = '1,
    parameter int              DEBOUNCE_CYC      = 1_000_000,
    parameter logic [N_CH-1:0] REPEAT_EN         = '1,
    parameter int              REPEAT_DELAY_CYC  = 25_000_000,
    parameter int              REPEAT_PERIOD_CYC = 5_000_000
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    input  logic [N_CH-1:0] raw,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] repeat_pulse,
    output logic            any_press
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        key_channel #(
            .ACTIVE_LOW        (ACTIVE_LOW[i]),
            .REPEAT_EN         (REPEAT_EN[i]),
            .DEBOUNCE_CYC      (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC  (REPEAT_DELAY_CYC),
            .REPEAT_PERIOD_CYC (REPEAT_PERIOD_CYC)
        ) u_ch (
            .clk_sys       (CLOCK_50),
            .reset         (RESET),
            .raw           (raw[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i]),
            .repeat_pulse  (repeat_pulse[i])
        );
    end

    assign any_press = |press;

endmodule
